// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Frame layout: sync byte, 16-bit little-endian word count, data bytes, XOR checksum.
package loader_pkg;

    localparam int         WC_W      = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word; the complete
// pulse and the word are combinational so the parent can register them once.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic        o_complete,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // The first byte of a word drifts down to [7:0] as later bytes arrive.
    assign o_complete = i_byte_en && (r_cnt == 2'd3);
    assign o_word     = {i_byte, r_shift};

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_en) begin
            r_shift <= {i_byte, r_shift[23:8]};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: parses a framed byte stream, writes 32-bit words into the
// instruction memory and holds the core in reset until the checksum matches.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          MAX_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        hold_cpu,
    output logic        done,
    output logic        error
);

    localparam logic [WC_W:0]   LP_MAX = (WC_W + 1)'(MAX_WORDS);
    localparam logic [WC_W-1:0] LP_ONE = WC_W'(1);

    state_t            r_state;
    state_t            w_state_nx;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [63:0]       r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_hold_cpu;
    logic              r_done;
    logic              r_error;
    logic [7:0]        r_acc;
    logic [7:0]        r_len_lo;
    logic [WC_W-1:0]   r_len;
    logic [WC_W-1:0]   r_word_idx;

    logic              w_fire;
    logic              w_is_sync;
    logic              w_frame_start;
    logic              w_byte_en;
    logic              w_complete;
    logic [31:0]       w_word;
    logic [WC_W-1:0]   w_len;
    logic              w_in_hdr_data;

    assign w_fire        = in_valid && r_in_ready;
    assign w_is_sync     = (in_data == SYNC_BYTE);
    assign w_len         = {in_data, r_len_lo};
    assign w_frame_start = w_fire && w_is_sync &&
                           (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);
    assign w_byte_en     = w_fire && (r_state == ST_DATA);
    assign w_in_hdr_data = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                           (r_state == ST_DATA);

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_frame_start),
        .i_byte_en  (w_byte_en),
        .i_byte     (in_data),
        .o_complete (w_complete),
        .o_word     (w_word)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_fire) begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: if (w_is_sync) w_state_nx = ST_LEN_LO;
                ST_LEN_LO: w_state_nx = ST_LEN_HI;
                ST_LEN_HI: begin
                    if ({1'b0, w_len} > LP_MAX) w_state_nx = ST_ERROR;
                    else if (w_len == '0)       w_state_nx = ST_CSUM;
                    else                        w_state_nx = ST_DATA;
                end
                ST_DATA: if (w_complete && (r_word_idx == r_len - LP_ONE)) w_state_nx = ST_CSUM;
                ST_CSUM: w_state_nx = (in_data == r_acc) ? ST_DONE : ST_ERROR;
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    // Status flags follow the next state so they change together with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_hold_cpu <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_acc      <= '0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
        end else begin
            r_in_ready <= 1'b1;
            r_wr_en    <= w_complete;
            r_hold_cpu <= (w_state_nx != ST_DONE);
            r_done     <= (w_state_nx == ST_DONE);
            r_error    <= (w_state_nx == ST_ERROR);

            if (w_complete) begin
                r_wr_addr  <= BASE_ADDR + {{(62 - WC_W){1'b0}}, r_word_idx, 2'b00};
                r_wr_data  <= w_word;
                r_word_idx <= r_word_idx + LP_ONE;
            end

            if (w_frame_start)
                r_acc <= '0;
            else if (w_fire && w_in_hdr_data)
                r_acc <= r_acc ^ in_data;

            if (w_fire && r_state == ST_LEN_LO)
                r_len_lo <= in_data;

            if (w_fire && r_state == ST_LEN_HI) begin
                r_len      <= w_len;
                r_word_idx <= '0;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign hold_cpu = r_hold_cpu;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; two instances with different base
// addresses share one byte stream so address offsets are checked too.
module tb_instr_mem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready, wr_en, hold_cpu, done, error;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        b_in_ready, b_wr_en, b_hold_cpu, b_done, b_error;
    logic [63:0] b_wr_addr;
    logic [31:0] b_wr_data;

    instr_mem_loader #(.BASE_ADDR(64'h0), .MAX_WORDS(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .hold_cpu(hold_cpu), .done(done), .error(error)
    );

    instr_mem_loader #(.BASE_ADDR(64'h100), .MAX_WORDS(16)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .hold_cpu(b_hold_cpu), .done(b_done), .error(b_error)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [63:0] qb_addr[$];
    logic [31:0] qb_data[$];

    always @(negedge clk) begin
        if (wr_en) begin
            qa_addr.push_back(wr_addr);
            qa_data.push_back(wr_data);
        end
        if (b_wr_en) begin
            qb_addr.push_back(b_wr_addr);
            qb_data.push_back(b_wr_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int maxgap);
        foreach (fr[i]) send(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] fr[$]);
        logic [7:0] s = 8'h00;
        for (int i = 1; i < fr.size(); i++) s = s ^ fr[i];
        return s;
    endfunction

    task automatic expect_writes(input string tag, input int n, input logic [31:0] d[$]);
        check({tag, " count"},   64'(qa_addr.size()), 64'(n));
        check({tag, " count_b"}, 64'(qb_addr.size()), 64'(n));
        for (int i = 0; i < n && i < qa_addr.size() && i < qb_addr.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i),   qa_addr[i], 64'(4 * i));
            check($sformatf("%s data%0d", tag, i),   {32'h0, qa_data[i]}, {32'h0, d[i]});
            check($sformatf("%s addr_b%0d", tag, i), qb_addr[i], 64'h100 + 64'(4 * i));
            check($sformatf("%s data_b%0d", tag, i), {32'h0, qb_data[i]}, {32'h0, d[i]});
        end
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " wr_en"},    64'(wr_en),    64'd0);
        check({tag, " wr_addr"},  wr_addr,       64'd0);
        check({tag, " wr_data"},  64'(wr_data),  64'd0);
        check({tag, " hold"},     64'(hold_cpu), 64'd1);
        check({tag, " done"},     64'(done),     64'd0);
        check({tag, " error"},    64'(error),    64'd0);
        check({tag, " b_wr_addr"}, b_wr_addr,    64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  f2[$];
        logic [7:0]  fr[$];
        logic [31:0] none[$];
        logic [31:0] w2[$];

        f2 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        w2 = '{32'h0000_0013, 32'h0010_0093};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // Two-word frame at full rate, with write and checksum timing probed.
        fr = f2;
        fr.push_back(xsum(f2));
        foreach (fr[i]) begin
            send(fr[i], 0);
            if (i == 6) begin
                check("t1 w0 wr_en",   64'(wr_en),   64'd1);
                check("t1 w0 wr_addr", wr_addr,      64'h0);
                check("t1 w0 wr_data", 64'(wr_data), 64'h13);
            end
            if (i == 7) check("t1 wr_en drops", 64'(wr_en), 64'd0);
            if (i == 10) begin
                check("t1 w1 wr_en",   64'(wr_en),   64'd1);
                check("t1 w1 wr_data", 64'(wr_data), 64'h0010_0093);
                check("t1 done early", 64'(done),    64'd0);
            end
            if (i == 11) begin
                check("t1 done",  64'(done),     64'd1);
                check("t1 hold",  64'(hold_cpu), 64'd0);
                check("t1 error", 64'(error),    64'd0);
                check("t1 wr_en idle", 64'(wr_en), 64'd0);
            end
        end
        expect_writes("t1", 2, w2);

        // Bad checksum; the restart from DONE must reassert hold immediately.
        send(8'hA5, 0);
        check("t2 restart hold", 64'(hold_cpu), 64'd1);
        check("t2 restart done", 64'(done),     64'd0);
        fr = f2[1:$];
        fr.push_back(8'h00);
        send_frame(fr, 0);
        check("t2 error", 64'(error),    64'd1);
        check("t2 hold",  64'(hold_cpu), 64'd1);
        check("t2 done",  64'(done),     64'd0);
        expect_writes("t2", 2, w2);

        // Oversize length (17 words) is rejected straight from the header.
        send_frame('{8'hA5, 8'h11, 8'h00}, 0);
        check("t3 error", 64'(error), 64'd1);
        check("t3 hold",  64'(hold_cpu), 64'd1);
        expect_writes("t3 over", 0, none);
        send_frame('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09}, 0);
        check("t3 done",  64'(done),  64'd1);
        check("t3 error clr", 64'(error), 64'd0);
        expect_writes("t3 one", 1, '{32'h1234_5678});

        // Garbage is ignored in DONE, then the frame arrives with random gaps.
        send_frame('{8'h00, 8'hFF, 8'h5A}, 0);
        check("t4 garbage done", 64'(done),     64'd1);
        check("t4 garbage hold", 64'(hold_cpu), 64'd0);
        expect_writes("t4 garbage", 0, none);
        fr = f2;
        fr.push_back(8'h92);
        send_frame(fr, 3);
        check("t4 done",  64'(done),  64'd1);
        check("t4 b_done", 64'(b_done), 64'd1);
        expect_writes("t4", 2, w2);

        // Zero-length frame writes nothing in either instance.
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        check("t5 done",   64'(done),   64'd1);
        check("t5 b_done", 64'(b_done), 64'd1);
        expect_writes("t5", 0, none);

        // Reset after the second byte of word 1 discards the partial word.
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6 reset");
        @(negedge clk);
        reset = 1'b0;
        expect_writes("t6 partial", 1, '{32'h0000_0013});
        fr = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04};
        fr.push_back(xsum(fr));
        send_frame(fr, 0);
        check("t6 done", 64'(done),     64'd1);
        check("t6 hold", 64'(hold_cpu), 64'd0);
        expect_writes("t6 reload", 2, '{32'hDEAD_BEEF, 32'h0403_0201});

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
